// File: rtl/v810_ext_mem.sv
// V810 external-bus memory responder: decodes T1/T2 bus cycles, inserts wait
// states, requests 16-bit sizing for one region, backed by a byte-lane RAM.
module v810_ext_mem #(
   parameter int          AW          = 10,
   parameter int          WAIT_STATES = 0,
   parameter logic [7:0]  SIZ16_TAG   = 8'h07
) (
   input  logic          CLK,
   input  logic          RES,
   input  logic          CE,
   input  logic [31:0]   A,
   input  logic [31:0]   D_O,
   output logic [31:0]   D_I,
   input  logic [3:0]    BEn,
   input  logic [1:0]    ST,
   input  logic          DAn,
   input  logic          MRQn,
   input  logic          RW,
   input  logic          BCYSTn,
   output logic          READYn,
   output logic          SZRQn,
   input  logic          BD_WE,
   input  logic [AW-1:0] BD_A,
   input  logic [31:0]   BD_D,
   output logic [31:0]   BD_Q
);

   typedef enum logic {IDLE, DATA} state_t;

   state_t          state;
   logic [3:0]      cnt;
   logic [AW-1:0]   wa_q;
   logic            a1_q;
   logic            rw_q;
   logic            r16_q;

   logic [3:0][7:0] ram [0:(1<<AW)-1];

   logic            r16;
   logic            done;
   logic            h;
   logic [31:0]     word;
   logic [3:0]      lane_we;
   logic [3:0][7:0] wdata;
   logic            bus_we;
   logic            unused;

   assign unused = ^{ST, A[0], A[31:AW+2]};

   assign r16    = (A[31:24] == SIZ16_TAG);
   assign SZRQn  = ~(r16 & ~MRQn & (~BCYSTn | ~DAn));
   assign done   = (state == DATA) & ~DAn & (cnt == 4'd0);
   assign READYn = ~done;

   // Halfword select also honours "upper lanes only" enables on an even address.
   assign h      = a1_q | (BEn[1:0] == 2'b11);
   assign word   = ram[wa_q];
   assign BD_Q   = ram[BD_A];

   always_comb begin
      D_I = 32'h0;
      if (state == DATA && rw_q) begin
         if (r16_q) D_I = {16'h0, h ? word[31:16] : word[15:0]};
         else       D_I = word;
      end
   end

   always_comb begin
      if (r16_q) begin
         lane_we = h ? {~BEn[3:2], 2'b00} : {2'b00, ~BEn[1:0]};
         wdata   = {D_O[15:0], D_O[15:0]};
      end else begin
         lane_we = ~BEn;
         wdata   = D_O;
      end
   end

   assign bus_we = done & ~rw_q & CE & ~RES;

   // Bus write is issued after the backdoor so it wins on the lanes it enables.
   always_ff @(posedge CLK) begin
      if (CE && BD_WE) ram[BD_A] <= BD_D;
      if (bus_we) begin
         for (int i = 0; i < 4; i++)
            if (lane_we[i]) ram[wa_q][i] <= wdata[i];
      end
   end

   always_ff @(posedge CLK or posedge RES) begin
      if (RES) begin
         state <= IDLE;
         cnt   <= 4'd0;
         wa_q  <= '0;
         a1_q  <= 1'b0;
         rw_q  <= 1'b0;
         r16_q <= 1'b0;
      end else if (CE) begin
         case (state)
            IDLE: if (!BCYSTn && !MRQn) begin
               wa_q  <= A[AW+1:2];
               a1_q  <= A[1];
               rw_q  <= RW;
               r16_q <= r16;
               cnt   <= 4'(WAIT_STATES);
               state <= DATA;
            end
            DATA: if (!DAn) begin
               if (cnt != 4'd0) cnt <= cnt - 4'd1;
               else             state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
